stopwatch_timer_ctrl: RTL and testbench
=======================================

Name: stopwatch_timer_ctrl

Overview:
Sequencing controller for the HH:MM:SS counter chain behind the VGA clock display. Generates the 1 s tick and issues one-cycle count enables to the seconds, minutes and hours counters. Enables carry/borrow only when the lower digit wraps. Runs the start/pause/clear state machine for stopwatch (up) and countdown (down) modes, and flags completion when a countdown reaches 00:00:00.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count tick (minimum 3); test benches use 4.
SEC_MAX, 59, terminal value of the seconds and minutes counters.
HR_MAX, 23, terminal value of the hours counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, debounced: run/resume
stop  in  1  one-cycle pulse: pause
clear  in  1  one-cycle pulse: zero counters, return to IDLE
mode_fwd  in  1  1 = stopwatch (up), 0 = countdown (down); sampled only on start from IDLE
sec_val  in  6  current seconds counter value
min_val  in  6  current minutes counter value
hr_val  in  5  current hours counter value
cnt_fwd  out  1  latched direction to all counters
sec_en  out  1  one-cycle count enable, seconds
min_en  out  1  one-cycle count enable, minutes
hr_en  out  1  one-cycle count enable, hours
cnt_clr  out  1  one-cycle clear to all counters
running  out  1  high in RUN
done  out  1  high in DONE
alarm  out  1  alarm drive (see Optional Feature)

Behaviour:
- Reset: state IDLE, prescaler 0, cnt_fwd=1, all enables 0, cnt_clr=1 for the reset cycle only, running=0, done=0, alarm=0.
- Prescaler: 0..TICK_DIV-1, counts only in RUN. tick is internal and asserts when the prescaler equals TICK_DIV-1. The prescaler is held in PAUSE and zeroed on entry to RUN from IDLE and on clear.
- Enables are registered. A tick at cycle N produces enables during cycle N+1. Counters update at the end of N+1 and must be stable before the next tick (guaranteed by TICK_DIV>=3).
- Up mode on tick:
  - sec_en=1.
  - min_en=1 iff sec_val==SEC_MAX.
  - hr_en=1 iff sec_val==SEC_MAX and min_val==SEC_MAX.
  - 23:59:59 wraps to 00:00:00; the counters handle the wrap and the controller takes no extra action.
- Down mode on tick:
  - If sec_val, min_val and hr_val are all 0: no enables, go to DONE.
  - Otherwise: sec_en=1; min_en=1 iff sec_val==0; hr_en=1 iff sec_val==0 and min_val==0.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE --start--> RUN: latch cnt_fwd<=mode_fwd. A down-mode start with all values 0 goes directly to DONE.
  - RUN --stop--> PAUSE.
  - RUN --zero reached (down)--> DONE.
  - PAUSE --start--> RUN: direction unchanged, prescaler resumes from its held value.
  - DONE --start--> stays DONE; --clear--> IDLE.
  - Any state --clear--> IDLE with cnt_clr pulsed for one cycle and the prescaler zeroed.
- Simultaneous pulses: priority reset > clear > stop > start.
- A tick coinciding with stop is still issued (the count completes, then the block pauses). A tick coinciding with clear is discarded.
- mode_fwd changes outside IDLE are ignored.
- running = (state==RUN); done = (state==DONE).

Optional Feature:
STOPWATCH_ALARM_EN
- Defined: alarm toggles every tick while in DONE; the prescaler keeps running in DONE for this purpose. After 10 toggles alarm is forced to 0 and the state remains DONE.
- Undefined: alarm is tied to 0 and the prescaler is idle in DONE.

Decomposition:
- Shared package stopwatch_pkg: state enum (IDLE=0, RUN=1, PAUSE=2, DONE=3), width constants SEC_W=6 and HR_W=5, default SEC_MAX/HR_MAX.
- One natural sub-module: tick_prescaler, with inputs clk, reset, run and zero, output tick, parameter TICK_DIV.

Test Plan:
1. TICK_DIV=4, up mode, start with counters at 00:00:58. At the first tick sec_en=1; at the second tick sec_en=min_en=1 (sec_val=59); hr_en=0.
2. Up mode at 00:59:59, one tick -> sec_en=min_en=hr_en=1 in the same cycle, exactly one cycle wide.
3. Down mode from 00:01:00, one tick -> sec_en=min_en=1, hr_en=0. Countdown continues to 00:00:00; the next tick gives no enables, done=1, running=0.
4. Stop after 2 prescaler counts, hold 20 cycles, then start -> the next tick arrives 2 cycles after resume and cnt_fwd is unchanged.
5. clear and start in the same cycle while RUN -> state IDLE, cnt_clr high 1 cycle, no enables. Reset asserted mid-RUN -> all outputs at reset values next cycle.
6. With STOPWATCH_ALARM_EN, reach DONE -> alarm toggles every 4 cycles for 10 toggles, then stays 0. Without the macro, alarm stays 0 throughout.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and width/limit constants for the HH:MM:SS sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SEC_W         = 6;
    localparam int HR_W          = 5;
    localparam int SEC_MAX_DEF   = 59;
    localparam int HR_MAX_DEF    = 23;
    localparam int ALARM_TOGGLES = 10;

endpackage

// File: rtl/stopwatch_timer_ctrl_tick_prescaler.sv
// Free-running tick divider: counts 0..TICK_DIV-1 while run is high, holds otherwise.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || zero) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // A zeroing cycle swallows the tick so a clear never leaks a count enable.
    assign tick = run && !zero && (count == LAST);

endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// Start/pause/clear sequencer issuing carry/borrow-aware count enables to the HH:MM:SS chain.
// Optional alarm toggling in DONE is built when STOPWATCH_ALARM_EN is defined.
module stopwatch_timer_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SEC_MAX  = SEC_MAX_DEF,
    parameter int HR_MAX   = HR_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    input  logic            mode_fwd,
    input  logic [SEC_W-1:0] sec_val,
    input  logic [SEC_W-1:0] min_val,
    input  logic [HR_W-1:0]  hr_val,
    output logic            cnt_fwd,
    output logic            sec_en,
    output logic            min_en,
    output logic            hr_en,
    output logic            cnt_clr,
    output logic            running,
    output logic            done,
    output logic            alarm,
    output logic [1:0]      state_dbg
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

    if (TICK_DIV < 3 || SEC_MAX >= (1 << SEC_W) || HR_MAX >= (1 << HR_W)) begin : g_bad_param
        $error("stopwatch_timer_ctrl: parameter out of range");
    end

    state_t state, state_next;
    logic   fwd_next, sec_next, min_next, hr_next;
    logic   tick, pre_run, pre_zero, all_zero;

    assign all_zero = (sec_val == '0) && (min_val == '0) && (hr_val == '0);
    assign pre_zero = clear || (state == ST_IDLE);
`ifdef STOPWATCH_ALARM_EN
    assign pre_run  = (state == ST_RUN) || (state == ST_DONE);
`else
    assign pre_run  = (state == ST_RUN);
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (pre_run),
        .zero  (pre_zero),
        .tick  (tick)
    );

    always_comb begin
        state_next = state;
        fwd_next   = cnt_fwd;
        sec_next   = 1'b0;
        min_next   = 1'b0;
        hr_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    fwd_next   = mode_fwd;
                    state_next = (!mode_fwd && all_zero) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) state_next = ST_PAUSE;
                // A tick alongside stop still completes its count before pausing.
                if (tick) begin
                    if (cnt_fwd) begin
                        sec_next = 1'b1;
                        min_next = (sec_val == SEC_LAST);
                        hr_next  = (sec_val == SEC_LAST) && (min_val == SEC_LAST);
                    end else if (all_zero) begin
                        state_next = ST_DONE;
                    end else begin
                        sec_next = 1'b1;
                        min_next = (sec_val == '0);
                        hr_next  = (sec_val == '0) && (min_val == '0);
                    end
                end
            end
            ST_PAUSE: begin
                if (start && !stop) state_next = ST_RUN;
            end
            ST_DONE: ;
            default: state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
            sec_next   = 1'b0;
            min_next   = 1'b0;
            hr_next    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt_fwd <= 1'b1;
            sec_en  <= 1'b0;
            min_en  <= 1'b0;
            hr_en   <= 1'b0;
            cnt_clr <= 1'b1;
        end else begin
            state   <= state_next;
            cnt_fwd <= fwd_next;
            sec_en  <= sec_next;
            min_en  <= min_next;
            hr_en   <= hr_next;
            cnt_clr <= clear;
        end
    end

`ifdef STOPWATCH_ALARM_EN
    logic [3:0] toggles;

    always_ff @(posedge clk) begin
        if (reset || clear || state != ST_DONE) begin
            alarm   <= 1'b0;
            toggles <= '0;
        end else if (tick) begin
            if (toggles < 4'(ALARM_TOGGLES)) begin
                alarm   <= !alarm;
                toggles <= toggles + 1'b1;
            end else begin
                alarm <= 1'b0;
            end
        end
    end
`else
    assign alarm = 1'b0;
`endif

    assign running   = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Directed bench for stopwatch_timer_ctrl with TICK_DIV=4 and a behavioural HH:MM:SS counter chain.
module tb_stopwatch_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, clear, mode_fwd;
    logic [5:0] sec_q = '0, min_q = '0;
    logic [4:0] hr_q = '0;
    logic       ld;
    logic [5:0] ld_s, ld_m;
    logic [4:0] ld_h;
    logic       cnt_fwd, sec_en, min_en, hr_en, cnt_clr, running, done, alarm;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .mode_fwd  (mode_fwd),
        .sec_val   (sec_q),
        .min_val   (min_q),
        .hr_val    (hr_q),
        .cnt_fwd   (cnt_fwd),
        .sec_en    (sec_en),
        .min_en    (min_en),
        .hr_en     (hr_en),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .done      (done),
        .alarm     (alarm),
        .state_dbg (state_dbg)
    );

    // Counter chain driven by the controller's enables and direction.
    always @(posedge clk) begin
        if (ld) begin
            sec_q <= ld_s;
            min_q <= ld_m;
            hr_q  <= ld_h;
        end else if (cnt_clr) begin
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else begin
            if (sec_en) sec_q <= cnt_fwd ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                                         : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
            if (min_en) min_q <= cnt_fwd ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                                         : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
            if (hr_en)  hr_q  <= cnt_fwd ? ((hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1)
                                         : ((hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        clear = c;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic preset(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        ld   = 1'b1;
        ld_h = h;
        ld_m = m;
        ld_s = s;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sec_en && n < 40);
        check("tick_seen", sec_en, 1'b1);
    endtask

    initial begin
        int n;
        int toggles;
        int first;
        logic prev;
        logic en_seen;

        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; mode_fwd = 1'b1;
        ld = 1'b0; ld_s = '0; ld_m = '0; ld_h = '0;
        repeat (2) @(negedge clk);
        check("rst_state", state_dbg, 2'd0);
        check("rst_cnt_clr", cnt_clr, 1'b1);
        check("rst_cnt_fwd", cnt_fwd, 1'b1);
        check("rst_enables", {sec_en, min_en, hr_en}, 3'b000);
        check("rst_flags", {running, done, alarm}, 3'b000);
        reset = 1'b0;
        @(negedge clk);
        check("rst_clr_release", cnt_clr, 1'b0);

        // Up mode from 00:00:58: plain second, then second with minute carry.
        preset(5'd0, 6'd0, 6'd58);
        mode_fwd = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        check("t1_running", running, 1'b1);
        wait_tick(n);
        check("t1_first_lat", n, 4);
        check("t1_first_en", {sec_en, min_en, hr_en}, 3'b100);
        @(negedge clk);
        check("t1_en_width", sec_en, 1'b0);
        wait_tick(n);
        check("t1_second_lat", n, 3);
        check("t1_second_en", {sec_en, min_en, hr_en}, 3'b110);

        // Up mode from 00:59:59: full carry into hours, one cycle wide.
        pulse(1'b0, 1'b0, 1'b1);
        check("t2_clr_pulse", cnt_clr, 1'b1);
        check("t2_clr_idle", state_dbg, 2'd0);
        preset(5'd0, 6'd59, 6'd59);
        check("t2_clr_width", cnt_clr, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick(n);
        check("t2_lat", n, 4);
        check("t2_full_carry", {sec_en, min_en, hr_en}, 3'b111);
        @(negedge clk);
        check("t2_carry_width", {sec_en, min_en, hr_en}, 3'b000);

        // Countdown from 00:01:00 down to zero.
        pulse(1'b0, 1'b0, 1'b1);
        preset(5'd0, 6'd1, 6'd0);
        mode_fwd = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        check("t3_cnt_fwd", cnt_fwd, 1'b0);
        mode_fwd = 1'b1;
        wait_tick(n);
        check("t3_lat", n, 4);
        check("t3_borrow", {sec_en, min_en, hr_en}, 3'b110);
        check("t3_mode_ignored", cnt_fwd, 1'b0);
        for (int i = 0; i < 59; i++) wait_tick(n);
        n = 0;
        en_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (sec_en || min_en || hr_en) en_seen = 1'b1;
        end while (!done && n < 20);
        check("t3_done", done, 1'b1);
        check("t3_not_running", running, 1'b0);
        check("t3_done_lat", n, 4);
        check("t3_no_en_at_zero", en_seen, 1'b0);
        check("t3_counters_zero", {hr_q, min_q, sec_q}, 17'd0);

        // Alarm behaviour while sitting in DONE.
        toggles = 0;
        first = 0;
        prev = alarm;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (alarm !== prev) begin
                toggles++;
                if (first == 0) first = i;
            end
            prev = alarm;
        end
`ifdef STOPWATCH_ALARM_EN
        check("t6_toggles", toggles, 10);
        check("t6_first_toggle", first, 4);
`else
        check("t6_toggles", toggles, 0);
`endif
        check("t6_alarm_final", alarm, 1'b0);
        check("t6_done_hold", done, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        check("t3_start_in_done", {running, done}, 2'b01);
        pulse(1'b0, 1'b0, 1'b1);
        check("t3_clear_done", state_dbg, 2'd0);
        check("t3_clear_pulse", cnt_clr, 1'b1);

        // Pause after two prescaler counts; resume picks up the held count.
        preset(5'd0, 6'd0, 6'd0);
        mode_fwd = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        check("t4_paused", state_dbg, 2'd2);
        check("t4_not_running", running, 1'b0);
        en_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (sec_en) en_seen = 1'b1;
        end
        check("t4_no_en_in_pause", en_seen, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick(n);
        check("t4_resume_lat", n, 2);
        check("t4_dir_kept", cnt_fwd, 1'b1);

        // clear together with start on a tick cycle.
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b1);
        check("t5_clr_idle", state_dbg, 2'd0);
        check("t5_clr_pulse", cnt_clr, 1'b1);
        check("t5_tick_dropped", {sec_en, min_en, hr_en}, 3'b000);
        check("t5_not_running", running, 1'b0);
        @(negedge clk);
        check("t5_clr_width", cnt_clr, 1'b0);
        check("t5_still_no_en", {sec_en, min_en, hr_en}, 3'b000);

        // Reset in the middle of a countdown, on a tick cycle.
        preset(5'd0, 6'd0, 6'd30);
        mode_fwd = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick(n);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_state", state_dbg, 2'd0);
        check("t5_rst_cnt_fwd", cnt_fwd, 1'b1);
        check("t5_rst_cnt_clr", cnt_clr, 1'b1);
        check("t5_rst_enables", {sec_en, min_en, hr_en}, 3'b000);
        check("t5_rst_flags", {running, done, alarm}, 3'b000);
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_clr_width", cnt_clr, 1'b0);

        // Countdown started at 00:00:00 goes straight to DONE.
        preset(5'd0, 6'd0, 6'd0);
        mode_fwd = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        check("t3_zero_start_done", {running, done}, 2'b01);
        check("t3_zero_start_dir", cnt_fwd, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check("t3_zero_start_clear", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
